tcp_tx_arbiter: RTL



---
 rtl/tcp_tx_arb_pkg.sv | 19 +
 rtl/tcp_tx_arbiter_rr.sv | 30 +++
 rtl/tcp_tx_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/tcp_tx_arb_pkg.sv
// Shared types and widths for the SiTCP transmit arbiter.
// TCP_TX_ARB_CHKSUM_EN adds the trailing XOR checksum state.
package tcp_tx_arb_pkg;

    localparam int LEN_W = 8;
    localparam int DROP_W = 16;
    localparam logic [3:0] HDR_MAGIC_DEF = 4'hA;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LEN,
        S_PAYLOAD
`ifdef TCP_TX_ARB_CHKSUM_EN
        , S_CSUM
`endif
    } state_t;

endpackage

// File: rtl/tcp_tx_arbiter_rr.sv
// Combinational round-robin pick: first requester after ptr, wrapping.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] id
);

    logic         found;
    logic [W-1:0] cand;

    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = W'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                id          = cand;
            end
        end
    end

endmodule

// File: rtl/tcp_tx_arbiter.sv
// Round-robin framer of NUM_SRC producers onto the SiTCP TX FIFO write port.
// Define TCP_TX_ARB_CHKSUM_EN to append an XOR checksum byte to every frame.
module tcp_tx_arbiter
    import tcp_tx_arb_pkg::*;
#(
    parameter int         NUM_SRC   = 4,
    parameter logic [3:0] HDR_MAGIC = HDR_MAGIC_DEF
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_SRC-1:0]       SRC_REQ,
    input  logic [LEN_W*NUM_SRC-1:0] SRC_LEN,
    input  logic [8*NUM_SRC-1:0]     SRC_DATA,
    output logic [NUM_SRC-1:0]       SRC_ACK,
    output logic [NUM_SRC-1:0]       SRC_GRANT,
    input  logic                     TX_OPEN,
    input  logic                     TX_FULL,
    output logic [7:0]               TX_DATA,
    output logic                     TX_EN,
    output logic                     BUSY,
    output logic [DROP_W-1:0]        DROP_CNT
);

    localparam int ID_W = $clog2(NUM_SRC);

`ifdef TCP_TX_ARB_CHKSUM_EN
    localparam state_t S_TAIL = S_CSUM;
`else
    localparam state_t S_TAIL = S_IDLE;
`endif

    state_t            state;
    logic [ID_W-1:0]   id;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   pick_id;
    logic [NUM_SRC-1:0] pick_gnt;
    logic [LEN_W-1:0]  len_q;
    logic [8:0]        len_cnt;
    logic              lost;
    logic              step;
    logic              emit;
    logic              frame_end;
    logic [7:0]        hdr_byte;
    logic [7:0]        out_byte;
`ifdef TCP_TX_ARB_CHKSUM_EN
    logic [7:0]        csum;
`endif

    logic [LEN_W-1:0]  len_arr  [NUM_SRC];
    logic [7:0]        data_arr [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign len_arr[i]  = SRC_LEN[LEN_W*i +: LEN_W];
        assign data_arr[i] = SRC_DATA[8*i +: 8];
    end

    rr_arbiter #(
        .N (NUM_SRC),
        .W (ID_W)
    ) u_rr (
        .req   (SRC_REQ),
        .ptr   (rr_ptr),
        .grant (pick_gnt),
        .id    (pick_id)
    );

    // A lost connection keeps the FSM draining the source, ignoring FULL.
    assign step     = !TX_FULL || !TX_OPEN;
    assign emit     = !TX_FULL && TX_OPEN;
    assign hdr_byte = {HDR_MAGIC, 4'(id)};
    assign BUSY     = (state != S_IDLE);
    assign SRC_ACK  = (state == S_PAYLOAD && step) ? SRC_GRANT : '0;

    always_comb begin
        out_byte = hdr_byte;
        unique case (state)
            S_LEN:     out_byte = len_q;
            S_PAYLOAD: out_byte = data_arr[id];
`ifdef TCP_TX_ARB_CHKSUM_EN
            S_CSUM:    out_byte = csum;
`endif
            default:   out_byte = hdr_byte;
        endcase
    end

`ifdef TCP_TX_ARB_CHKSUM_EN
    assign frame_end = step && (state == S_CSUM);
`else
    assign frame_end = step &&
        ((state == S_LEN && len_q == '0) ||
         (state == S_PAYLOAD && len_cnt == 9'd1));
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            rr_ptr    <= ID_W'(NUM_SRC - 1);
            id        <= '0;
            len_q     <= '0;
            len_cnt   <= '0;
            lost      <= 1'b0;
            SRC_GRANT <= '0;
            TX_DATA   <= 8'h00;
            TX_EN     <= 1'b0;
            DROP_CNT  <= '0;
`ifdef TCP_TX_ARB_CHKSUM_EN
            csum      <= 8'h00;
`endif
        end else begin
            TX_EN <= 1'b0;
            if (state != S_IDLE && step) begin
                TX_EN <= emit;
                if (emit) TX_DATA <= out_byte;
`ifdef TCP_TX_ARB_CHKSUM_EN
                csum <= (state == S_HDR) ? hdr_byte : (csum ^ out_byte);
`endif
            end
            if (state != S_IDLE && !TX_OPEN) lost <= 1'b1;

            unique case (state)
                S_IDLE: begin
                    lost <= 1'b0;
                    if (TX_OPEN && |SRC_REQ) begin
                        id        <= pick_id;
                        rr_ptr    <= pick_id;
                        len_q     <= len_arr[pick_id];
                        len_cnt   <= {1'b0, len_arr[pick_id]};
                        SRC_GRANT <= pick_gnt;
                        state     <= S_HDR;
                    end
                end
                S_HDR: if (step) state <= S_LEN;
                S_LEN: if (step) begin
                    state <= (len_q == '0) ? S_TAIL : S_PAYLOAD;
                end
                S_PAYLOAD: if (step) begin
                    len_cnt <= len_cnt - 9'd1;
                    if (len_cnt == 9'd1) state <= S_TAIL;
                end
`ifdef TCP_TX_ARB_CHKSUM_EN
                S_CSUM: if (step) state <= S_IDLE;
`endif
                default: state <= S_IDLE;
            endcase

            if (frame_end) begin
                SRC_GRANT <= '0;
                if ((lost || !TX_OPEN) && DROP_CNT != '1)
                    DROP_CNT <= DROP_CNT + DROP_W'(1);
            end
        end
    end

endmodule
